// File: rtl/adc_cal_pkg.sv
// ---------------------------------------------------------------------------
// adc_cal_pkg
// Shared definitions for the ADC IDELAY auto-calibration block:
//   - cal_state_t     : calibration FSM state encoding
//   - CAL_TAP_W       : default IDELAY tap-value width
//   - CAL_DEFAULT_TAP : default tap used after reset and for failed lanes
// ---------------------------------------------------------------------------
package adc_cal_pkg;

    localparam int unsigned CAL_TAP_W       = 5;
    localparam int unsigned CAL_DEFAULT_TAP = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_CHECK,
        ST_EVAL,
        ST_CENTER,
        ST_NEXT_LANE,
        ST_DONE
    } cal_state_t;

endpackage

// File: rtl/adc_cal_window_tracker.sv
// ---------------------------------------------------------------------------
// adc_cal_window_tracker
// Tracks the current run of passing taps and the best (longest, earliest on
// ties) passing window seen during one lane sweep, and derives the centre tap.
// Ports:
//   clk, arst_n   clock / asynchronous active-low reset
//   i_clear       clear all trackers (start of a lane sweep)
//   i_eval        one-cycle strobe: account the result for tap i_tap
//   i_pass        result of the tap being evaluated (1 = no mismatch seen)
//   i_tap         tap value being evaluated
//   o_final_tap   centre of best window, or DEFAULT_TAP when window too short
//   o_win_ok      best window length >= MIN_WIN
// ---------------------------------------------------------------------------
module adc_cal_window_tracker
    import adc_cal_pkg::*;
#(
    parameter int unsigned TAP_W       = CAL_TAP_W,
    parameter int unsigned MIN_WIN     = 3,
    parameter int unsigned DEFAULT_TAP = CAL_DEFAULT_TAP
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             i_clear,
    input  logic             i_eval,
    input  logic             i_pass,
    input  logic [TAP_W-1:0] i_tap,
    output logic [TAP_W-1:0] o_final_tap,
    output logic             o_win_ok
);

    localparam logic [TAP_W:0] C_MIN_LEN = (TAP_W+1)'(MIN_WIN);

    // Lengths are one bit wider than taps so a full-range window fits.
    logic [TAP_W-1:0] r_run_start;
    logic [TAP_W:0]   r_run_len;
    logic [TAP_W-1:0] r_best_start;
    logic [TAP_W:0]   r_best_len;

    logic [TAP_W-1:0] w_run_start;
    logic [TAP_W:0]   w_run_len;

    always_comb begin
        w_run_start = (r_run_len == '0) ? i_tap : r_run_start;
        w_run_len   = r_run_len + 1'b1;
    end

    // The best window is promoted while a run grows; a strict '>' keeps the
    // earlier run when a later one only reaches the same length.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_run_start  <= '0;
            r_run_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
        end else if (i_clear) begin
            r_run_start  <= '0;
            r_run_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
        end else if (i_eval) begin
            if (i_pass) begin
                r_run_start <= w_run_start;
                r_run_len   <= w_run_len;
                if (w_run_len > r_best_len) begin
                    r_best_start <= w_run_start;
                    r_best_len   <= w_run_len;
                end
            end else begin
                r_run_len <= '0;
            end
        end
    end

    // start + floor(len/2) never exceeds the last tap of the window.
    always_comb begin
        o_win_ok    = (r_best_len >= C_MIN_LEN);
        o_final_tap = o_win_ok ? (r_best_start + r_best_len[TAP_W:1])
                               : TAP_W'(DEFAULT_TAP);
    end

endmodule

// File: rtl/adc_idelay_autocal.sv
// ---------------------------------------------------------------------------
// adc_idelay_autocal
// Per-lane IDELAY tap sweep against a known training word. Each lane is swept
// over all taps (load, settle, check), the longest passing window is found and
// the lane is loaded with the window centre (or DEFAULT_TAP if too short).
// Ports:
//   clk              ADC divided clock, rising edge
//   arst_n           asynchronous active-low reset
//   cal_start        single-cycle calibration request (ignored while busy)
//   adc_data_i       deserialised words, channel c at slice c
//   idelay_ld        per-lane one-cycle tap load strobe
//   idelay_cntvalue  per-lane tap value (always the lane's last loaded tap)
//   cal_busy         sweep in progress
//   cal_done         calibration finished (sticky until next cal_start)
//   cal_err          at least one lane failed
//   lane_fail        per-lane failure flag
// ---------------------------------------------------------------------------
module adc_idelay_autocal
    import adc_cal_pkg::*;
#(
    parameter int unsigned NUM_CH            = 2,
    parameter int unsigned ADC_DATA_WIDTH    = 8,
    parameter int unsigned PARALLEL_PATH_NUM = 2,
    parameter int unsigned TAP_W             = CAL_TAP_W,
    parameter int unsigned SETTLE_CYC        = 16,
    parameter int unsigned CHECK_LEN         = 64,
    parameter int unsigned MIN_WIN           = 3,
    parameter int unsigned DEFAULT_TAP       = CAL_DEFAULT_TAP,
    parameter logic [ADC_DATA_WIDTH*PARALLEL_PATH_NUM-1:0] TRAIN_PATTERN = 16'h55AA
) (
    input  logic                                               clk,
    input  logic                                               arst_n,
    input  logic                                               cal_start,
    input  logic [NUM_CH*ADC_DATA_WIDTH*PARALLEL_PATH_NUM-1:0] adc_data_i,
    output logic [NUM_CH*ADC_DATA_WIDTH-1:0]                   idelay_ld,
    output logic [NUM_CH*ADC_DATA_WIDTH*TAP_W-1:0]             idelay_cntvalue,
    output logic                                               cal_busy,
    output logic                                               cal_done,
    output logic                                               cal_err,
    output logic [NUM_CH*ADC_DATA_WIDTH-1:0]                   lane_fail
);

    localparam int unsigned NUM_LANES = NUM_CH * ADC_DATA_WIDTH;
    localparam int unsigned WORD_W    = ADC_DATA_WIDTH * PARALLEL_PATH_NUM;
    localparam int unsigned LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned CNT_MAX   = (SETTLE_CYC > CHECK_LEN) ? SETTLE_CYC : CHECK_LEN;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  C_SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  C_CHECK_LAST  = CNT_W'(CHECK_LEN - 1);
    localparam logic [LANE_W-1:0] C_LAST_LANE   = LANE_W'(NUM_LANES - 1);
    localparam logic [TAP_W-1:0]  C_TAP_MAX     = '1;

    cal_state_t        r_state, w_next;
    logic [LANE_W-1:0] r_lane;
    logic [TAP_W-1:0]  r_tap;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_tap_fail;
    logic              r_done;
    logic              r_err;
    logic [NUM_LANES-1:0] r_lane_fail;
    logic [TAP_W-1:0]  r_cntval [NUM_LANES];

    logic [NUM_LANES-1:0] w_lane_err;
    logic              w_clear;
    logic              w_eval;
    logic              w_ld_any;
    logic [TAP_W-1:0]  w_ld_val;
    logic [TAP_W-1:0]  w_final_tap;
    logic              w_win_ok;

    // Lane c*ADC_DATA_WIDTH+b sees bit p*ADC_DATA_WIDTH+b of channel c's word.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        for (genvar b = 0; b < ADC_DATA_WIDTH; b++) begin : g_bit
            logic [PARALLEL_PATH_NUM-1:0] w_diff;
            for (genvar p = 0; p < PARALLEL_PATH_NUM; p++) begin : g_path
                assign w_diff[p] = adc_data_i[c*WORD_W + p*ADC_DATA_WIDTH + b]
                                 ^ TRAIN_PATTERN[p*ADC_DATA_WIDTH + b];
            end
            assign w_lane_err[c*ADC_DATA_WIDTH + b] = |w_diff;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (cal_start) w_next = ST_LOAD;
            ST_LOAD:      w_next = ST_SETTLE;
            ST_SETTLE:    if (r_cnt == C_SETTLE_LAST) w_next = ST_CHECK;
            ST_CHECK:     if (r_cnt == C_CHECK_LAST) w_next = ST_EVAL;
            ST_EVAL:      w_next = (r_tap == C_TAP_MAX) ? ST_CENTER : ST_LOAD;
            ST_CENTER:    w_next = ST_NEXT_LANE;
            ST_NEXT_LANE: w_next = (r_lane == C_LAST_LANE) ? ST_DONE : ST_LOAD;
            ST_DONE:      w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_clear  = ((r_state == ST_IDLE) && cal_start)
                || ((r_state == ST_NEXT_LANE) && (r_lane != C_LAST_LANE));
        w_eval   = (r_state == ST_EVAL);
        w_ld_any = (r_state == ST_LOAD) || (r_state == ST_CENTER);
        w_ld_val = (r_state == ST_LOAD) ? r_tap : w_final_tap;
    end

    adc_cal_window_tracker #(
        .TAP_W       (TAP_W),
        .MIN_WIN     (MIN_WIN),
        .DEFAULT_TAP (DEFAULT_TAP)
    ) u_tracker (
        .clk         (clk),
        .arst_n      (arst_n),
        .i_clear     (w_clear),
        .i_eval      (w_eval),
        .i_pass      (~r_tap_fail),
        .i_tap       (r_tap),
        .o_final_tap (w_final_tap),
        .o_win_ok    (w_win_ok)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_lane      <= '0;
            r_tap       <= '0;
            r_cnt       <= '0;
            r_tap_fail  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_lane_fail <= '0;
            for (int unsigned l = 0; l < NUM_LANES; l++) r_cntval[l] <= TAP_W'(DEFAULT_TAP);
        end else begin
            if (((r_state == ST_SETTLE) || (r_state == ST_CHECK)) && (w_next == r_state))
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (cal_start) begin
                        r_lane <= '0;
                        r_tap  <= '0;
                        r_done <= 1'b0;
                        r_err  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_tap_fail       <= 1'b0;
                    r_cntval[r_lane] <= r_tap;
                end
                ST_CHECK: begin
                    if (w_lane_err[r_lane]) r_tap_fail <= 1'b1;
                end
                ST_EVAL: begin
                    if (r_tap != C_TAP_MAX) r_tap <= r_tap + 1'b1;
                end
                ST_CENTER: begin
                    r_cntval[r_lane]    <= w_final_tap;
                    r_lane_fail[r_lane] <= ~w_win_ok;
                end
                ST_NEXT_LANE: begin
                    if (r_lane == C_LAST_LANE) begin
                        // Flags rise as DONE is entered so they are visible in DONE.
                        r_done <= 1'b1;
                        r_err  <= |r_lane_fail;
                    end else begin
                        r_lane <= r_lane + 1'b1;
                        r_tap  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // The tap being loaded is presented together with its strobe; afterwards
    // the lane shows the value held in r_cntval.
    always_comb begin
        idelay_ld       = '0;
        idelay_cntvalue = '0;
        if (w_ld_any) idelay_ld[r_lane] = 1'b1;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            idelay_cntvalue[l*TAP_W +: TAP_W] =
                (w_ld_any && (r_lane == LANE_W'(l))) ? w_ld_val : r_cntval[l];
        end
    end

    assign cal_busy  = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign cal_done  = r_done;
    assign cal_err   = r_err;
    assign lane_fail = r_lane_fail;

endmodule
